mbox_responder: RTL

MBOX_RESPONDER -- requirements
Module: mbox_responder

---
 rtl/kl10pkg.sv | 11 +
 rtl/mbox_ram.sv | 35 +++
 rtl/mbox_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/kl10pkg.sv
// rtl/kl10pkg.sv - shared KL10 EBOX/MBOX types: word width, MBOX state, latency default.
package kl10pkg;
  localparam int WORD_W               = 36;
  localparam int MBOX_LATENCY_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mbox_state_e;
endpackage

// File: rtl/mbox_ram.sv
// rtl/mbox_ram.sv - MEM_WORDS x 36 storage, synchronous write, registered read.
module mbox_ram
  import kl10pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int AW        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [MEM_WORDS];
  logic [WORD_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // Array has no reset so its contents survive eboxReset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mbox_responder.sv
// rtl/mbox_responder.sv - EBOX memory responder: fixed-latency request FSM, NXM decode, storage.
module mbox_responder
  import kl10pkg::*;
#(
  parameter int LATENCY   = MBOX_LATENCY_DEFAULT,
  parameter int MEM_WORDS = 256
) (
  input  logic         eboxClk,
  input  logic         eboxReset,
  input  logic         memReq,
  input  logic         memWrite,
  input  logic [27:35] MA,
  input  logic [0:35]  cacheDataWrite,
  output logic [0:35]  cacheDataRead,
  output logic         memAck,
  output logic         memBusy,
  output logic         memNXM
);
  localparam int         AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  mbox_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [8:0]        addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              nxm_q, nxm_d;
  logic              rd_zero_q, rd_zero_d;

  logic [8:0]        addr_cur;
  logic              wr_cur;
  logic [WORD_W-1:0] wdata_cur;
  logic              enter_ack;
  logic              cur_nxm;
  logic              ram_we, ram_re;
  logic [WORD_W-1:0] ram_rdata;

  // The accepting posedge counts as the first of LATENCY posedges, so the
  // ACK edge is the one where the counter steps from 1 to 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rd_zero_d = rd_zero_q;
    enter_ack = 1'b0;
    addr_cur  = addr_q;
    wr_cur    = wr_q;
    wdata_cur = wdata_q;

    case (state_q)
      IDLE: begin
        if (memReq) begin
          addr_cur  = MA;
          wr_cur    = memWrite;
          wdata_cur = cacheDataWrite;
          addr_d    = addr_cur;
          wr_d      = wr_cur;
          wdata_d   = wdata_cur;
          if (LATENCY == 1) begin
            state_d   = ACK;
            cnt_d     = 4'd0;
            enter_ack = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d   = ACK;
          cnt_d     = 4'd0;
          enter_ack = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cur_nxm = ({1'b0, addr_cur} >= 10'(MEM_WORDS));
    ack_d   = enter_ack;
    busy_d  = (state_d != IDLE);
    nxm_d   = enter_ack && cur_nxm;
    if (enter_ack && !wr_cur) rd_zero_d = cur_nxm;

    // Gate with reset so an LATENCY=1 accept cannot touch storage while reset is held.
    ram_we = enter_ack && wr_cur && !cur_nxm && !eboxReset;
    ram_re = enter_ack && !wr_cur && !cur_nxm && !eboxReset;
  end

  always_ff @(posedge eboxClk or posedge eboxReset) begin
    if (eboxReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      nxm_q     <= 1'b0;
      rd_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      nxm_q     <= nxm_d;
      rd_zero_q <= rd_zero_d;
    end
  end

  mbox_ram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_ram (
    .clk   (eboxClk),
    .rst   (eboxReset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_cur[AW-1:0]),
    .wdata (wdata_cur),
    .rdata (ram_rdata)
  );

  assign cacheDataRead = rd_zero_q ? '0 : ram_rdata;
  assign memAck        = ack_q;
  assign memBusy       = busy_q;
  assign memNXM        = nxm_q;
endmodule
